// File: rtl/uart_defs.sv
// Shared UART constants and FSM encodings.
// Used by both the transmit and receive stages.
package uart_defs;

  localparam int CLK_FREQ     = 50_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int DATA_BITS    = 8;
  localparam int STOP_BITS    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the transmitter.
// First-word-fall-through: rd_data always shows the head.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_transmit.sv
// 8N1 serial transmitter with a write-side byte FIFO.
// FSM, baud counter and shift register live here.
module uart_transmit
  import uart_defs::*;
#(
  parameter int CLK_FREQ     = uart_defs::CLK_FREQ,
  parameter int BAUD         = uart_defs::BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_en,
  output logic                          tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          tx_busy,
  output logic                          tx_overflow,
  output logic                          tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);

  uart_state_t   state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          busy_d;
  logic          tx_d;
  logic          pop;
  logic          last;
  logic [7:0]    head;
  logic          empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_en),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (tx_full),
    .empty   (empty),
    .count   (tx_count)
  );

  assign last = (cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    busy_d  = tx_busy;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (last) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DATA: begin
        if (last) begin
          cnt_d   = '0;
          shift_d = shift >> 1;
          if (idx == IW'(DATA_BITS - 1)) state_d = STOP;
          else idx_d = idx + IW'(1);
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      STOP: begin
        if (last) begin
          cnt_d = '0;
          // Chain straight into the next frame, no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      tx_busy     <= 1'b0;
      tx          <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      shift       <= shift_d;
      tx_busy     <= busy_d;
      tx          <= tx_d;
      tx_overflow <= tx_overflow | (tx_en & tx_full);
    end
  end

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit at a short bit time.
// A line monitor decodes frames off tx into a queue.
module tb_uart_transmit;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_en = 1'b0;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       tx_busy;
  logic       tx_overflow;
  logic       tx;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] rx_q [$];

  uart_transmit #(
    .CLK_FREQ   (50_000_000),
    .BAUD       (3_125_000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_full     (tx_full),
    .tx_count    (tx_count),
    .tx_busy     (tx_busy),
    .tx_overflow (tx_overflow),
    .tx          (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] d);
    tx_en   = 1'b1;
    tx_data = d;
    @(posedge clk); #1;
    tx_en = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line monitor: mid-bit sampling, like a receiver.
  initial begin
    logic [7:0] d;
    forever begin
      @(posedge clk); #1;
      if (!rst && tx === 1'b0) begin
        step(CPB / 2);
        for (int i = 0; i < 8; i++) begin
          step(CPB);
          d[i] = tx;
        end
        step(CPB);
        check("stop_bit", 32'(tx), 32'd1);
        rx_q.push_back(d);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] frm;
    int c_rise;
    int viol;
    bit done;

    // Reset hold with tx_en toggling.
    #1;
    for (int i = 0; i < 5; i++) begin
      tx_en   = i[0];
      tx_data = 8'hC3;
      step(1);
      check("rst_hold", 32'({tx, tx_busy, tx_count, tx_overflow}),
            32'({1'b1, 1'b0, 5'd0, 1'b0}));
    end
    tx_en = 1'b0;
    rst   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'(i * 37);
      step(1);
      check("en_low", 32'({tx, tx_count}), 32'({1'b1, 5'd0}));
    end

    // Single byte 0xA5: exact bit levels and boundaries.
    rx_q.delete();
    put(8'hA5);
    step(1);
    check("a5_busy_rise", 32'(tx_busy), 32'd1);
    frm = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      check($sformatf("a5_bit%0d_first", b), 32'(tx), 32'(frm[b]));
      step(CPB - 1);
      check($sformatf("a5_bit%0d_last", b), 32'(tx), 32'(frm[b]));
      step(1);
    end
    check("a5_busy_fall", 32'({tx_busy, tx}), 32'({1'b0, 1'b1}));
    check("a5_rx_len", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("a5_rx_data", 32'(rx_q[0]), 32'hA5);

    // Back-to-back 0x00, 0xFF, 0x3C.
    step(3);
    rx_q.delete();
    put(8'h00);
    put(8'hFF);
    c_rise = cyc;
    check("b2b_busy", 32'(tx_busy), 32'd1);
    check("b2b_cnt_e1", 32'(tx_count), 32'd1);
    put(8'h3C);
    check("b2b_cnt_e2", 32'(tx_count), 32'd2);
    done = 1'b0;
    while (!done) begin
      step(1);
      if (cyc == c_rise + 10*CPB - 1)
        check("b2b_cnt_f1", 32'(tx_count), 32'd2);
      if (cyc == c_rise + 10*CPB)
        check("b2b_cnt_f2", 32'(tx_count), 32'd1);
      if (cyc == c_rise + 20*CPB)
        check("b2b_cnt_f3", 32'(tx_count), 32'd0);
      if (!tx_busy || cyc - c_rise > 40*CPB) done = 1'b1;
    end
    check("b2b_len", 32'(cyc - c_rise), 32'(30*CPB));
    step(2);
    check("b2b_rx_len", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check("b2b_rx0", 32'(rx_q[0]), 32'h00);
      check("b2b_rx1", 32'(rx_q[1]), 32'hFF);
      check("b2b_rx2", 32'(rx_q[2]), 32'h3C);
    end

    // Overflow: 17 writes behind a running frame.
    step(3);
    rx_q.delete();
    put(8'hEE);
    step(2);
    for (int i = 1; i <= 17; i++) begin
      put(8'(i));
      if (i == 15)
        check("ovf_full15", 32'({tx_full, tx_count}), 32'({1'b0, 5'd15}));
      if (i == 16)
        check("ovf_full16", 32'({tx_full, tx_count, tx_overflow}),
              32'({1'b1, 5'd16, 1'b0}));
      if (i == 17)
        check("ovf_set", 32'({tx_full, tx_count, tx_overflow}),
              32'({1'b1, 5'd16, 1'b1}));
    end
    viol = 0;
    while (tx_busy && viol < 20*10*CPB) begin
      step(1);
      viol++;
    end
    check("ovf_drain", 32'(tx_busy), 32'd0);
    step(2);
    check("ovf_sticky", 32'(tx_overflow), 32'd1);
    check("ovf_rx_len", 32'(rx_q.size()), 32'd17);
    if (rx_q.size() == 17) begin
      check("ovf_rx_head", 32'(rx_q[0]), 32'hEE);
      for (int k = 1; k <= 16; k++)
        check($sformatf("ovf_rx%0d", k), 32'(rx_q[k]), 32'(k));
    end

    // Reset mid-frame with 3 bytes queued.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_clr_ovf", 32'(tx_overflow), 32'd0);
    put(8'h5A);
    put(8'h11);
    put(8'h22);
    put(8'h33);
    check("mid_cnt", 32'(tx_count), 32'd3);
    step(3*CPB);
    check("mid_busy", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    step(1);
    check("mid_rst", 32'({tx, tx_busy, tx_count, tx_full}),
          32'({1'b1, 1'b0, 5'd0, 1'b0}));
    step(1);
    rst  = 1'b0;
    viol = 0;
    for (int i = 0; i < 30*CPB; i++) begin
      step(1);
      if (tx !== 1'b1 || tx_busy !== 1'b0) viol++;
    end
    check("mid_quiet", 32'(viol), 32'd0);
    check("mid_cnt_end", 32'(tx_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
